// File: rtl/btb_pkg.sv
// Shared types and helpers for the BTB/RAS branch predictor.
package btb_pkg;

    typedef enum logic [2:0] {
        ENT_JUMP    = 3'd0,
        ENT_BRANCH  = 3'd1,
        ENT_CALL    = 3'd2,
        ENT_RETURN  = 3'd3,
        ENT_CALLRET = 3'd4
    } entry_type_e;

    localparam int unsigned PC_STEP = 4;

    function automatic int unsigned tag_width(int unsigned xlen, int unsigned index_width);
        return xlen - index_width - 2;
    endfunction

    // Weakly-taken start value: MSB set, all other bits clear.
    function automatic int unsigned ctr_init(int unsigned width);
        return 1 << (width - 1);
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return address stack: push overwrites the oldest entry when full, pop on empty is a no-op.
module return_address_stack #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            push_data,
    output logic [XLEN-1:0]            top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  stack [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;
    logic [PTR_W-1:0] wr_ptr;

    assign top = stack[ptr];

    // Push+pop on a non-empty stack rewrites the top in place; on an empty stack it is a plain push.
    always_comb begin
        do_replace = push && pop && (count != '0);
        do_push    = push && !do_replace;
        do_pop     = pop && !push && (count != '0);
        wr_ptr     = do_replace ? ptr : ptr + PTR_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH))
                count <= count + CNT_W'(1);
        end else if (do_pop) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push || do_replace)
            stack[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/btb_ras_predictor.sv
// Set-associative BTB with saturating branch counters and a speculative return address stack.
import btb_pkg::*;

module btb_ras_predictor #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned INDEX_WIDTH   = 5,
    parameter int unsigned WAYS          = 2,
    parameter int unsigned COUNTER_WIDTH = 2,
    parameter int unsigned RAS_DEPTH     = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [XLEN-1:0]               fetch_PC,
    input  logic                          fetch_valid,
    output logic [XLEN-1:0]               target_PC,
    output logic                          target_take,
    output logic                          BTB_hit,
    input  logic                          update_valid,
    input  logic [XLEN-1:0]               update_fetch_PC,
    input  logic [XLEN-1:0]               update_target_PC,
    input  logic                          update_is_branch,
    input  logic                          update_branch_taken,
    input  logic                          update_rs1_is_link,
    input  logic                          update_rd_is_link,
    input  logic                          update_rs1_is_rd,
    input  logic                          update_BTB_hit,
    output logic [$clog2(RAS_DEPTH):0]    ras_count
);

    localparam int unsigned SETS  = 1 << INDEX_WIDTH;
    localparam int unsigned TAG_W = tag_width(XLEN, INDEX_WIDTH);
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = COUNTER_WIDTH'(ctr_init(COUNTER_WIDTH));

    logic                     valid   [SETS][WAYS];
    logic [TAG_W-1:0]         tags    [SETS][WAYS];
    logic [XLEN-1:0]          targets [SETS][WAYS];
    entry_type_e              types   [SETS][WAYS];
    logic [COUNTER_WIDTH-1:0] ctrs    [SETS][WAYS];
    logic [WAY_W-1:0]         rr_ptr  [SETS];

    logic [INDEX_WIDTH-1:0]   f_idx;
    logic [TAG_W-1:0]         f_tag;
    logic [XLEN-1:0]          seq_pc;
    logic                     f_match;
    logic [WAY_W-1:0]         f_way;
    entry_type_e              f_type;
    logic [XLEN-1:0]          f_target;
    logic [COUNTER_WIDTH-1:0] f_ctr;

    logic                     ras_push;
    logic                     ras_pop;
    logic [XLEN-1:0]          ras_top;

    logic [INDEX_WIDTH-1:0]   u_idx;
    logic [TAG_W-1:0]         u_tag;
    logic                     u_match;
    logic [WAY_W-1:0]         u_way;
    logic                     u_free;
    logic [WAY_W-1:0]         u_free_way;
    logic [WAY_W-1:0]         u_way_sel;
    entry_type_e              u_type;
    logic                     u_write;
    logic                     u_rr_advance;
    logic [COUNTER_WIDTH-1:0] u_base_ctr;
    logic [COUNTER_WIDTH-1:0] u_new_ctr;

    // The fetch-time hit hint is advisory: a fresh tag compare decides hit versus miss.
    logic unused_inputs;
    assign unused_inputs = ^{update_BTB_hit, update_fetch_PC[1:0]};

    assign f_idx  = fetch_PC[INDEX_WIDTH+1:2];
    assign f_tag  = fetch_PC[XLEN-1:INDEX_WIDTH+2];
    assign seq_pc = fetch_PC + XLEN'(PC_STEP);

    always_comb begin
        f_match = 1'b0;
        f_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!f_match && valid[f_idx][w] && tags[f_idx][w] == f_tag) begin
                f_match = 1'b1;
                f_way   = WAY_W'(w);
            end
        end
    end

    assign f_type   = types[f_idx][f_way];
    assign f_target = targets[f_idx][f_way];
    assign f_ctr    = ctrs[f_idx][f_way];

    always_comb begin
        BTB_hit     = fetch_valid && f_match;
        target_take = 1'b0;
        target_PC   = seq_pc;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        if (BTB_hit) begin
            case (f_type)
                ENT_JUMP: begin
                    target_take = 1'b1;
                    target_PC   = f_target;
                end
                ENT_CALL: begin
                    target_take = 1'b1;
                    target_PC   = f_target;
                    ras_push    = 1'b1;
                end
                ENT_BRANCH: begin
                    target_take = f_ctr[COUNTER_WIDTH-1];
                    target_PC   = f_ctr[COUNTER_WIDTH-1] ? f_target : seq_pc;
                end
                ENT_RETURN, ENT_CALLRET: begin
                    target_take = 1'b1;
                    target_PC   = (ras_count != '0) ? ras_top : f_target;
                    ras_pop     = 1'b1;
                    ras_push    = (f_type == ENT_CALLRET);
                end
                default: ;
            endcase
        end
    end

    return_address_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .count     (ras_count)
    );

    assign u_idx = update_fetch_PC[INDEX_WIDTH+1:2];
    assign u_tag = update_fetch_PC[XLEN-1:INDEX_WIDTH+2];

    always_comb begin
        u_match    = 1'b0;
        u_way      = '0;
        u_free     = 1'b0;
        u_free_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!u_match && valid[u_idx][w] && tags[u_idx][w] == u_tag) begin
                u_match = 1'b1;
                u_way   = WAY_W'(w);
            end
            if (!u_free && !valid[u_idx][w]) begin
                u_free     = 1'b1;
                u_free_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        if (update_rd_is_link && !update_rs1_is_link)
            u_type = ENT_CALL;
        else if (update_rs1_is_link && !update_rd_is_link)
            u_type = ENT_RETURN;
        else if (update_rs1_is_link && update_rd_is_link)
            u_type = update_rs1_is_rd ? ENT_CALL : ENT_CALLRET;
        else if (update_is_branch)
            u_type = ENT_BRANCH;
        else
            u_type = ENT_JUMP;
    end

    // A fresh branch entry starts weakly taken and then absorbs the outcome that allocated it.
    always_comb begin
        u_way_sel    = u_match ? u_way : (u_free ? u_free_way : rr_ptr[u_idx]);
        u_write      = update_valid && (u_match || !(u_type == ENT_BRANCH && !update_branch_taken));
        u_rr_advance = u_write && !u_match && !u_free;
        u_base_ctr   = (u_match && types[u_idx][u_way] == ENT_BRANCH) ? ctrs[u_idx][u_way] : CTR_INIT;
        u_new_ctr    = u_base_ctr;
        if (u_type == ENT_BRANCH) begin
            if (update_branch_taken) begin
                if (u_base_ctr != '1)
                    u_new_ctr = u_base_ctr + COUNTER_WIDTH'(1);
            end else if (u_base_ctr != '0) begin
                u_new_ctr = u_base_ctr - COUNTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    ctrs[s][w]  <= '0;
                end
            end
        end else if (u_write) begin
            valid[u_idx][u_way_sel] <= 1'b1;
            ctrs[u_idx][u_way_sel]  <= u_new_ctr;
            if (u_rr_advance)
                rr_ptr[u_idx] <= (rr_ptr[u_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[u_idx] + WAY_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (u_write) begin
            tags[u_idx][u_way_sel]    <= u_tag;
            targets[u_idx][u_way_sel] <= update_target_PC;
            types[u_idx][u_way_sel]   <= u_type;
        end
    end

endmodule

// File: tb/tb_btb_ras_predictor.sv
// Table-driven scoreboard bench for btb_ras_predictor (default parameters).
module tb_btb_ras_predictor;

    logic        clock;
    logic        reset;
    logic [63:0] fetch_PC;
    logic        fetch_valid;
    logic [63:0] target_PC;
    logic        target_take;
    logic        BTB_hit;
    logic        update_valid;
    logic [63:0] update_fetch_PC;
    logic [63:0] update_target_PC;
    logic        update_is_branch;
    logic        update_branch_taken;
    logic        update_rs1_is_link;
    logic        update_rd_is_link;
    logic        update_rs1_is_rd;
    logic        update_BTB_hit;
    logic [3:0]  ras_count;

    btb_ras_predictor #(
        .XLEN          (64),
        .INDEX_WIDTH   (5),
        .WAYS          (2),
        .COUNTER_WIDTH (2),
        .RAS_DEPTH     (8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .fetch_PC            (fetch_PC),
        .fetch_valid         (fetch_valid),
        .target_PC           (target_PC),
        .target_take         (target_take),
        .BTB_hit             (BTB_hit),
        .update_valid        (update_valid),
        .update_fetch_PC     (update_fetch_PC),
        .update_target_PC    (update_target_PC),
        .update_is_branch    (update_is_branch),
        .update_branch_taken (update_branch_taken),
        .update_rs1_is_link  (update_rs1_is_link),
        .update_rd_is_link   (update_rd_is_link),
        .update_rs1_is_rd    (update_rs1_is_rd),
        .update_BTB_hit      (update_BTB_hit),
        .ras_count           (ras_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          is_upd;
        bit          fv;
        logic [63:0] pc;
        logic [63:0] tgt;
        bit          br, tk, rs1l, rdl, rsrd;
        bit          e_hit, e_take;
        logic [63:0] e_tgt;
        int unsigned e_cnt;
    } vec_t;

    typedef struct {
        string       name;
        bit          hit, take;
        logic [63:0] tgt;
        int unsigned cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t fch(logic [63:0] pc, bit h, bit t, logic [63:0] tg, int unsigned c);
        vec_t v;
        v = '{default: '0};
        v.fv = 1'b1; v.pc = pc; v.e_hit = h; v.e_take = t; v.e_tgt = tg; v.e_cnt = c;
        return v;
    endfunction

    function automatic vec_t upd(logic [63:0] pc, logic [63:0] tg, bit br, bit tk, bit rs1l, bit rdl, bit rsrd);
        vec_t v;
        v = '{default: '0};
        v.is_upd = 1'b1; v.pc = pc; v.tgt = tg;
        v.br = br; v.tk = tk; v.rs1l = rs1l; v.rdl = rdl; v.rsrd = rsrd;
        return v;
    endfunction

    task automatic check(input exp_t e);
        n_vec++;
        if (BTB_hit !== e.hit || target_take !== e.take || target_PC !== e.tgt || ras_count !== 4'(e.cnt)) begin
            n_err++;
            $display("FAIL %s: got hit=%0b take=%0b target=%h count=%0d, want hit=%0b take=%0b target=%h count=%0d",
                     e.name, BTB_hit, target_take, target_PC, ras_count, e.hit, e.take, e.tgt, e.cnt);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0)
            check(exp_q.pop_front());
    end

    task automatic idle();
        fetch_valid = 1'b0; update_valid = 1'b0; update_is_branch = 1'b0;
        update_branch_taken = 1'b0; update_rs1_is_link = 1'b0; update_rd_is_link = 1'b0;
        update_rs1_is_rd = 1'b0; update_BTB_hit = 1'b0;
    endtask

    task automatic expect_fetch(string name, bit h, bit t, logic [63:0] tg, int unsigned c);
        exp_t e;
        e.name = name; e.hit = h; e.take = t; e.tgt = tg; e.cnt = c;
        exp_q.push_back(e);
    endtask

    initial begin
        vec_t v;
        exp_t e;

        // Basic jump / branch training (sets 0 and 16).
        vecs.push_back(fch(64'h100, 0, 0, 64'h104, 0));
        vecs.push_back(upd(64'h100, 64'h400, 0, 0, 0, 0, 0));
        vecs.push_back(fch(64'h100, 1, 1, 64'h400, 0));
        vecs.push_back(upd(64'h180, 64'h80, 1, 1, 0, 0, 0));
        vecs.push_back(fch(64'h180, 1, 1, 64'h80, 0));
        vecs.push_back(upd(64'h180, 64'h80, 1, 0, 0, 0, 0));
        vecs.push_back(fch(64'h180, 1, 1, 64'h80, 0));
        vecs.push_back(upd(64'h180, 64'h80, 1, 0, 0, 0, 0));
        vecs.push_back(fch(64'h180, 1, 0, 64'h184, 0));
        vecs.push_back(upd(64'h1C0, 64'h40, 1, 0, 0, 0, 0));
        vecs.push_back(fch(64'h1C0, 0, 0, 64'h1C4, 0));
        // Call/return pair; the call lands in set 0 and evicts 0x100.
        vecs.push_back(upd(64'h200, 64'h800, 0, 0, 0, 1, 0));
        vecs.push_back(upd(64'h810, 64'h900, 0, 0, 1, 0, 0));
        vecs.push_back(fch(64'h200, 1, 1, 64'h800, 0));
        vecs.push_back(fch(64'h810, 1, 1, 64'h204, 1));
        vecs.push_back(fch(64'h810, 1, 1, 64'h900, 0));
        vecs.push_back(fch(64'h100, 0, 0, 64'h104, 0));
        // Three PCs in set 8: round-robin evicts the first.
        vecs.push_back(upd(64'h020, 64'h500, 0, 0, 0, 0, 0));
        vecs.push_back(upd(64'h0A0, 64'h600, 0, 0, 0, 0, 0));
        vecs.push_back(upd(64'h120, 64'h700, 0, 0, 0, 0, 0));
        vecs.push_back(fch(64'h020, 0, 0, 64'h024, 0));
        vecs.push_back(fch(64'h0A0, 1, 1, 64'h600, 0));
        vecs.push_back(fch(64'h120, 1, 1, 64'h700, 0));
        v = fch(64'h0A0, 0, 0, 64'h0A4, 0);
        v.fv = 1'b0;
        vecs.push_back(v);
        // RAS depth: nine calls, then ten returns.
        for (int i = 0; i < 9; i++)
            vecs.push_back(upd(64'h1000 + 64'(4 * i), 64'h3000, 0, 0, 0, 1, 0));
        vecs.push_back(upd(64'h2040, 64'h5000, 0, 0, 1, 0, 0));
        for (int i = 0; i < 9; i++)
            vecs.push_back(fch(64'h1000 + 64'(4 * i), 1, 1, 64'h3000, (i < 8) ? i : 8));
        for (int i = 0; i < 10; i++)
            vecs.push_back(fch(64'h2040, 1, 1, (i < 8) ? 64'h1024 - 64'(4 * i) : 64'h5000, (i < 8) ? 8 - i : 0));
        // Call-return (both link, rs1 != rd) replaces the top.
        vecs.push_back(upd(64'h2080, 64'h6000, 0, 0, 1, 1, 0));
        vecs.push_back(fch(64'h1000, 1, 1, 64'h3000, 0));
        vecs.push_back(fch(64'h2080, 1, 1, 64'h1004, 1));
        vecs.push_back(fch(64'h2040, 1, 1, 64'h2084, 1));
        vecs.push_back(fch(64'h2040, 1, 1, 64'h5000, 0));

        idle();
        fetch_PC = '0; update_fetch_PC = '0; update_target_PC = '0;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clock);
            #1;
            idle();
            if (vecs[i].is_upd) begin
                update_valid        = 1'b1;
                update_fetch_PC     = vecs[i].pc;
                update_target_PC    = vecs[i].tgt;
                update_is_branch    = vecs[i].br;
                update_branch_taken = vecs[i].tk;
                update_rs1_is_link  = vecs[i].rs1l;
                update_rd_is_link   = vecs[i].rdl;
                update_rs1_is_rd    = vecs[i].rsrd;
            end else begin
                fetch_valid = vecs[i].fv;
                fetch_PC    = vecs[i].pc;
                expect_fetch($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_take, vecs[i].e_tgt, vecs[i].e_cnt);
            end
        end

        // Same-cycle fetch and update of one PC: fetch sees the old state.
        @(posedge clock);
        #1;
        idle();
        fetch_valid      = 1'b1;
        fetch_PC         = 64'h3100;
        update_valid     = 1'b1;
        update_fetch_PC  = 64'h3100;
        update_target_PC = 64'h3500;
        expect_fetch("same_cycle_old", 0, 0, 64'h3104, 0);
        @(posedge clock);
        #1;
        idle();
        fetch_valid = 1'b1;
        fetch_PC    = 64'h3100;
        expect_fetch("same_cycle_new", 1, 1, 64'h3500, 0);

        // Asynchronous reset mid-cycle clears entries without a clock edge.
        @(posedge clock);
        #1;
        idle();
        fetch_valid = 1'b1;
        fetch_PC    = 64'h3100;
        #2 reset = 1'b1;
        #1;
        e.name = "async_reset"; e.hit = 0; e.take = 0; e.tgt = 64'h3104; e.cnt = 0;
        check(e);
        @(posedge clock);
        #1 reset = 1'b0;
        fetch_PC = 64'h2040;
        expect_fetch("after_reset", 0, 0, 64'h2044, 0);

        @(posedge clock);
        #1 idle();
        repeat (2) @(posedge clock);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
